// File: rtl/time_pkg.sv
// Shared constants, encodings and payload type for the time-set editor.
package time_pkg;

    localparam int unsigned VAL_W = 8;

    localparam logic [VAL_W-1:0] HOUR_MAX = VAL_W'(23);
    localparam logic [VAL_W-1:0] MIN_MAX  = VAL_W'(59);
    localparam logic [VAL_W-1:0] SEC_MAX  = VAL_W'(59);

    typedef enum logic [1:0] {
        FIELD_HOUR = 2'd0,
        FIELD_MIN  = 2'd1,
        FIELD_SEC  = 2'd2,
        FIELD_NONE = 2'd3
    } field_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_EDIT_HOUR = 3'd1,
        S_EDIT_MIN  = 3'd2,
        S_EDIT_SEC  = 3'd3,
        S_COMMIT    = 3'd4
    } state_e;

    typedef struct packed {
        logic [VAL_W-1:0] hour;
        logic [VAL_W-1:0] min;
        logic [VAL_W-1:0] sec;
    } hms_t;

    // Preload helper: a value above its field maximum loads as zero.
    function automatic logic [VAL_W-1:0] preload_clamp(input logic [VAL_W-1:0] v,
                                                       input logic [VAL_W-1:0] max);
        return (v > max) ? '0 : v;
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Edge detector plus hold-to-repeat generator for one level button.
module btn_repeat #(
    parameter int unsigned REPEAT_DELAY = 4,
    parameter int unsigned REPEAT_RATE  = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic clr,
    output logic press_c,
    output logic step_c
);
    localparam int unsigned CNT_W = $clog2(REPEAT_DELAY + 1);

    logic             btn_q, btn_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rep_c;

    // Press/repeat decode; after a repeat the counter rewinds so the next
    // step lands REPEAT_RATE cycles later. clr disarms until a fresh press.
    always_comb begin
        btn_d   = btn;
        armed_d = armed_q;
        cnt_d   = cnt_q;
        press_c = btn & ~btn_q;
        rep_c   = armed_q & btn & ~press_c & (cnt_q == CNT_W'(REPEAT_DELAY - 1));
        if (clr || !btn) begin
            armed_d = 1'b0;
            cnt_d   = '0;
        end else if (press_c) begin
            armed_d = 1'b1;
            cnt_d   = '0;
        end else if (rep_c) begin
            cnt_d = CNT_W'(REPEAT_DELAY - REPEAT_RATE);
        end else if (armed_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        step_c = press_c | rep_c;
    end

    // Button history and repeat counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q   <= 1'b0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            btn_q   <= btn_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/time_set_controller.sv
// Button-driven hour/min/sec editor issuing set_time / set_alarm commits.
module time_set_controller
    import time_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 4,
    parameter int unsigned REPEAT_RATE  = 2,
    parameter int unsigned TIMEOUT      = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_ok,
    input  logic       target_alarm,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    output logic [7:0] set_hour,
    output logic [7:0] set_min,
    output logic [7:0] set_sec,
    output logic       set_time,
    output logic       set_alarm,
    output logic       editing,
    output logic [1:0] edit_field,
    output logic       blink
);
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    state_e          state_q, state_d;
    hms_t            val_q, val_d;
    logic            tgt_q, tgt_d;
    logic            mode_hist_q, mode_hist_d;
    logic            ok_hist_q, ok_hist_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            set_time_q, set_time_d;
    logic            set_alarm_q, set_alarm_d;
    logic            editing_q, editing_d;
    field_e          field_q, field_d;
    logic            blink_q, blink_d;

    logic             press_mode_c, press_ok_c;
    logic             inc_press_c, dec_press_c, inc_step_c, dec_step_c;
    logic             in_edit_c, rep_clr_c, up_c, dn_c;
    logic [VAL_W-1:0] fld_val_c, fld_max_c;

    btn_repeat #(
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_inc (
        .clk    (clk),
        .reset  (reset),
        .btn    (btn_inc),
        .clr    (rep_clr_c),
        .press_c(inc_press_c),
        .step_c (inc_step_c)
    );

    btn_repeat #(
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_dec (
        .clk    (clk),
        .reset  (reset),
        .btn    (btn_dec),
        .clr    (rep_clr_c),
        .press_c(dec_press_c),
        .step_c (dec_step_c)
    );

    // Press qualifiers; a step only counts while the opposite button is released.
    always_comb begin
        press_mode_c = btn_mode & ~mode_hist_q;
        press_ok_c   = btn_ok & ~ok_hist_q;
        in_edit_c    = (state_q == S_EDIT_HOUR) || (state_q == S_EDIT_MIN) ||
                       (state_q == S_EDIT_SEC);
        rep_clr_c    = ~in_edit_c | press_mode_c | press_ok_c;
        up_c         = inc_step_c & ~btn_dec;
        dn_c         = dec_step_c & ~btn_inc;
    end

    // Next state, edited values, idle timeout and registered outputs.
    always_comb begin
        state_d     = state_q;
        val_d       = val_q;
        tgt_d       = tgt_q;
        to_d        = to_q;
        mode_hist_d = btn_mode;
        ok_hist_d   = btn_ok;
        fld_val_c   = '0;
        fld_max_c   = HOUR_MAX;

        case (state_q)
            S_IDLE: begin
                if (press_mode_c) begin
                    tgt_d      = target_alarm;
                    val_d.hour = preload_clamp(cur_hour, HOUR_MAX);
                    val_d.min  = preload_clamp(cur_min, MIN_MAX);
                    val_d.sec  = preload_clamp(cur_sec, SEC_MAX);
                    to_d       = '0;
                    state_d    = S_EDIT_HOUR;
                end
            end
            S_EDIT_HOUR, S_EDIT_MIN, S_EDIT_SEC: begin
                if (press_ok_c) begin
                    to_d    = '0;
                    state_d = S_COMMIT;
                end else if (press_mode_c) begin
                    to_d = '0;
                    case (state_q)
                        S_EDIT_HOUR: state_d = S_EDIT_MIN;
                        S_EDIT_MIN:  state_d = S_EDIT_SEC;
                        default:     state_d = S_EDIT_HOUR;
                    endcase
                end else begin
                    case (state_q)
                        S_EDIT_HOUR: begin fld_val_c = val_q.hour; fld_max_c = HOUR_MAX; end
                        S_EDIT_MIN:  begin fld_val_c = val_q.min;  fld_max_c = MIN_MAX;  end
                        default:     begin fld_val_c = val_q.sec;  fld_max_c = SEC_MAX;  end
                    endcase
                    if (up_c) begin
                        fld_val_c = (fld_val_c == fld_max_c) ? '0 : fld_val_c + VAL_W'(1);
                    end else if (dn_c) begin
                        fld_val_c = (fld_val_c == '0) ? fld_max_c : fld_val_c - VAL_W'(1);
                    end
                    case (state_q)
                        S_EDIT_HOUR: val_d.hour = fld_val_c;
                        S_EDIT_MIN:  val_d.min  = fld_val_c;
                        default:     val_d.sec  = fld_val_c;
                    endcase
                    if (inc_press_c || dec_press_c || up_c || dn_c) begin
                        to_d = '0;
                    end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                        to_d    = '0;
                        state_d = S_IDLE;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        set_time_d  = (state_q == S_COMMIT) & ~tgt_q;
        set_alarm_d = (state_q == S_COMMIT) & tgt_q;
        editing_d   = (state_d == S_EDIT_HOUR) || (state_d == S_EDIT_MIN) ||
                      (state_d == S_EDIT_SEC);
        case (state_d)
            S_EDIT_HOUR: field_d = FIELD_HOUR;
            S_EDIT_MIN:  field_d = FIELD_MIN;
            S_EDIT_SEC:  field_d = FIELD_SEC;
            default:     field_d = FIELD_NONE;
        endcase
        blink_d = editing_d & ~blink_q;
    end

    // State register and output flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            val_q       <= '0;
            tgt_q       <= 1'b0;
            mode_hist_q <= 1'b0;
            ok_hist_q   <= 1'b0;
            to_q        <= '0;
            set_time_q  <= 1'b0;
            set_alarm_q <= 1'b0;
            editing_q   <= 1'b0;
            field_q     <= FIELD_NONE;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            val_q       <= val_d;
            tgt_q       <= tgt_d;
            mode_hist_q <= mode_hist_d;
            ok_hist_q   <= ok_hist_d;
            to_q        <= to_d;
            set_time_q  <= set_time_d;
            set_alarm_q <= set_alarm_d;
            editing_q   <= editing_d;
            field_q     <= field_d;
            blink_q     <= blink_d;
        end
    end

    assign set_hour   = val_q.hour;
    assign set_min    = val_q.min;
    assign set_sec    = val_q.sec;
    assign set_time   = set_time_q;
    assign set_alarm  = set_alarm_q;
    assign editing    = editing_q;
    assign edit_field = field_q;
    assign blink      = blink_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: vector table, directed corner sequences, random vs model.
module tb_time_set_controller;

    localparam int RD  = 4;
    localparam int RR  = 2;
    localparam int TMO = 30;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode, btn_inc, btn_dec, btn_ok, target_alarm;
    logic [7:0] cur_hour, cur_min, cur_sec;
    logic [7:0] set_hour, set_min, set_sec;
    logic       set_time, set_alarm, editing, blink;
    logic [1:0] edit_field;

    int checks = 0;
    int errors = 0;

    time_set_controller #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .btn_ok(btn_ok), .target_alarm(target_alarm), .cur_hour(cur_hour), .cur_min(cur_min),
        .cur_sec(cur_sec), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .set_time(set_time), .set_alarm(set_alarm), .editing(editing),
        .edit_field(edit_field), .blink(blink)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // md: 0 idle, 1 hour, 2 min, 3 sec, 4 commit. Ages count edges since press (-1 = no repeat).
    int md, mtgt, midle, ia, da;
    int mv [3];
    bit pm_q, pi_q, pd_q, po_q;
    bit e_t, e_a, e_blink;

    function automatic int fmax(input int f);
        return (f == 0) ? 23 : 59;
    endfunction

    task automatic model_reset();
        md = 0; mtgt = 0; midle = 0; ia = -1; da = -1;
        mv[0] = 0; mv[1] = 0; mv[2] = 0;
        pm_q = 0; pi_q = 0; pd_q = 0; po_q = 0;
        e_t = 0; e_a = 0; e_blink = 0;
    endtask

    task automatic model_step(input bit m, input bit i, input bit d, input bit o, input bit ta,
                              input int ch, input int cm, input int cs);
        bit pm, pi, pd, po, ist, dst, up, dn, ed;
        int f, mx;
        pm = m && !pm_q; pi = i && !pi_q; pd = d && !pd_q; po = o && !po_q;
        ed = (md >= 1 && md <= 3);
        ist = pi;
        if (!i) ia = -1;
        else if (pi) ia = 0;
        else if (ia >= 0) begin
            ia++;
            if (ia >= RD && ((ia - RD) % RR) == 0) ist = 1;
        end
        dst = pd;
        if (!d) da = -1;
        else if (pd) da = 0;
        else if (da >= 0) begin
            da++;
            if (da >= RD && ((da - RD) % RR) == 0) dst = 1;
        end
        if (!ed || pm || po) begin ia = -1; da = -1; end
        up = ist && !d;
        dn = dst && !i;
        e_t = (md == 4) && (mtgt == 0);
        e_a = (md == 4) && (mtgt != 0);
        if (md == 0) begin
            if (pm) begin
                mtgt = int'(ta);
                mv[0] = (ch > 23) ? 0 : ch;
                mv[1] = (cm > 59) ? 0 : cm;
                mv[2] = (cs > 59) ? 0 : cs;
                md = 1; midle = 0;
            end
        end else if (ed) begin
            if (po) begin md = 4; midle = 0; end
            else if (pm) begin md = md % 3 + 1; midle = 0; end
            else begin
                f = md - 1; mx = fmax(f);
                if (up) mv[f] = (mv[f] + 1) % (mx + 1);
                else if (dn) mv[f] = (mv[f] + mx) % (mx + 1);
                if (pi || pd || up || dn) midle = 0;
                else begin
                    midle++;
                    if (midle >= TMO) begin md = 0; midle = 0; end
                end
            end
        end else begin
            md = 0;
        end
        e_blink = (md >= 1 && md <= 3) ? !e_blink : 1'b0;
        pm_q = m; pi_q = i; pd_q = d; po_q = o;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic m, input logic i, input logic d, input logic o, input logic ta,
                        input logic [7:0] ch, input logic [7:0] cm, input logic [7:0] cs);
        btn_mode = m; btn_inc = i; btn_dec = d; btn_ok = o; target_alarm = ta;
        cur_hour = ch; cur_min = cm; cur_sec = cs;
        @(posedge clk);
        model_step(m, i, d, o, ta, int'(ch), int'(cm), int'(cs));
        @(negedge clk);
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic zero_inputs();
        btn_mode = 0; btn_inc = 0; btn_dec = 0; btn_ok = 0; target_alarm = 0;
        cur_hour = 0; cur_min = 0; cur_sec = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_vals"}, 32'({set_hour, set_min, set_sec}), 32'(0));
        chk({tag, "_strb"}, 32'({set_time, set_alarm}), 32'(0));
        chk({tag, "_stat"}, 32'({editing, edit_field, blink}), 32'({1'b0, 2'd3, 1'b0}));
    endtask

    task automatic do_reset();
        zero_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic m, i, d, o, ta;
        logic [7:0] ch, cm, cs;
        logic [23:0] ev;
        logic [1:0]  es;
        logic        ee;
        logic [1:0]  ef;
    } vec_t;

    vec_t tbl [27];

    function automatic vec_t mk(input int m, input int i, input int d, input int o, input int ta,
                                input int ch, input int cm, input int cs,
                                input int eh, input int em, input int esec,
                                input int et, input int ea, input int ee, input int ef);
        vec_t r;
        r.m = 1'(m); r.i = 1'(i); r.d = 1'(d); r.o = 1'(o); r.ta = 1'(ta);
        r.ch = 8'(ch); r.cm = 8'(cm); r.cs = 8'(cs);
        r.ev = {8'(eh), 8'(em), 8'(esec)};
        r.es = {1'(et), 1'(ea)};
        r.ee = 1'(ee);
        r.ef = 2'(ef);
        return r;
    endfunction

    logic rm, ri, rd, ro;
    int   quiet;
    int   exp_min [10];

    initial begin
        zero_inputs();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        reset = 1'b0;

        // clock edit with hour wrap 22 -> 23 -> 0, commit to clock
        tbl[0]  = mk(1,0,0,0,0, 22,59,58, 22,59,58, 0,0,1,0);
        tbl[1]  = mk(0,0,0,0,0, 22,59,58, 22,59,58, 0,0,1,0);
        tbl[2]  = mk(0,1,0,0,0, 22,59,58, 23,59,58, 0,0,1,0);
        tbl[3]  = mk(0,0,0,0,0, 22,59,58, 23,59,58, 0,0,1,0);
        tbl[4]  = mk(0,1,0,0,0, 22,59,58,  0,59,58, 0,0,1,0);
        tbl[5]  = mk(0,0,0,0,0, 22,59,58,  0,59,58, 0,0,1,0);
        tbl[6]  = mk(0,0,0,1,0, 22,59,58,  0,59,58, 0,0,0,3);
        tbl[7]  = mk(0,0,0,0,0, 22,59,58,  0,59,58, 1,0,0,3);
        tbl[8]  = mk(0,0,0,0,0, 22,59,58,  0,59,58, 0,0,0,3);
        // alarm edit: second decrement wraps 0 -> 59; target change mid-edit ignored
        tbl[9]  = mk(1,0,0,0,1,  5,30, 0,  5,30, 0, 0,0,1,0);
        tbl[10] = mk(0,0,0,0,0,  5,30, 0,  5,30, 0, 0,0,1,0);
        tbl[11] = mk(1,0,0,0,0,  5,30, 0,  5,30, 0, 0,0,1,1);
        tbl[12] = mk(0,0,0,0,0,  5,30, 0,  5,30, 0, 0,0,1,1);
        tbl[13] = mk(1,0,0,0,0,  5,30, 0,  5,30, 0, 0,0,1,2);
        tbl[14] = mk(0,0,0,0,0,  5,30, 0,  5,30, 0, 0,0,1,2);
        tbl[15] = mk(0,0,1,0,0,  5,30, 0,  5,30,59, 0,0,1,2);
        tbl[16] = mk(0,0,0,0,0,  5,30, 0,  5,30,59, 0,0,1,2);
        tbl[17] = mk(0,0,0,1,0,  5,30, 0,  5,30,59, 0,0,0,3);
        tbl[18] = mk(0,0,0,0,0,  5,30, 0,  5,30,59, 0,1,0,3);
        tbl[19] = mk(0,0,0,0,0,  5,30, 0,  5,30,59, 0,0,0,3);
        // out-of-range preload, inc+dec together, ok+mode together
        tbl[20] = mk(1,0,0,0,0, 24,61,59,  0, 0,59, 0,0,1,0);
        tbl[21] = mk(0,0,0,0,0, 24,61,59,  0, 0,59, 0,0,1,0);
        tbl[22] = mk(0,1,1,0,0, 24,61,59,  0, 0,59, 0,0,1,0);
        tbl[23] = mk(0,0,0,0,0, 24,61,59,  0, 0,59, 0,0,1,0);
        tbl[24] = mk(1,0,0,1,0, 24,61,59,  0, 0,59, 0,0,0,3);
        tbl[25] = mk(0,0,0,0,0, 24,61,59,  0, 0,59, 1,0,0,3);
        tbl[26] = mk(0,0,0,0,0, 24,61,59,  0, 0,59, 0,0,0,3);

        for (int k = 0; k < 27; k++) begin
            step(tbl[k].m, tbl[k].i, tbl[k].d, tbl[k].o, tbl[k].ta, tbl[k].ch, tbl[k].cm, tbl[k].cs);
            chk($sformatf("tbl%0d_vals", k), 32'({set_hour, set_min, set_sec}), 32'(tbl[k].ev));
            chk($sformatf("tbl%0d_strb", k), 32'({set_time, set_alarm}), 32'(tbl[k].es));
            chk($sformatf("tbl%0d_stat", k), 32'({editing, edit_field}), 32'({tbl[k].ee, tbl[k].ef}));
        end

        // auto-repeat: minute 10, inc held for 10 edges -> steps at 0,4,6,8
        do_reset();
        step(1, 0, 0, 0, 0, 8'd3, 8'd10, 8'd0);
        idle_step();
        step(1, 0, 0, 0, 0, 8'd3, 8'd10, 8'd0);
        idle_step();
        chk("rep_field", 32'(edit_field), 32'(1));
        exp_min = '{11, 11, 11, 11, 12, 12, 13, 13, 14, 14};
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 0, 0, 0, 8'd0, 8'd0, 8'd0);
            chk($sformatf("rep_hold%0d", k), 32'(set_min), 32'(exp_min[k]));
        end
        for (int k = 0; k < 6; k++) begin
            idle_step();
            chk($sformatf("rep_rel%0d", k), 32'(set_min), 32'(14));
        end

        // timeout: 29 idle edges still editing, the 30th aborts without strobe
        do_reset();
        step(1, 0, 0, 0, 0, 8'd1, 8'd2, 8'd3);
        idle_step();
        step(0, 1, 0, 0, 0, 8'd0, 8'd0, 8'd0);
        chk("to_hour_inc", 32'(set_hour), 32'(2));
        repeat (29) idle_step();
        chk("to_before", 32'({editing, edit_field}), 32'({1'b1, 2'd0}));
        idle_step();
        chk("to_after", 32'({editing, edit_field}), 32'({1'b0, 2'd3}));
        chk("to_vals", 32'({set_hour, set_min, set_sec}), 32'({8'd2, 8'd2, 8'd3}));
        for (int k = 0; k < 3; k++) begin
            idle_step();
            chk($sformatf("to_strb%0d", k), 32'({set_time, set_alarm}), 32'(0));
        end

        // async reset while in EDIT_MIN
        do_reset();
        step(1, 0, 0, 0, 0, 8'd7, 8'd8, 8'd9);
        idle_step();
        step(1, 0, 0, 0, 0, 8'd0, 8'd0, 8'd0);
        idle_step();
        chk("rst_edit_pre", 32'({editing, edit_field}), 32'({1'b1, 2'd1}));
        #2 reset = 1'b1;
        #1 chk_reset_outputs("rst_edit");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        idle_step();
        chk("rst_edit_post", 32'({set_time, set_alarm, editing}), 32'(0));

        // async reset during the COMMIT cycle: no strobe ever appears
        step(1, 0, 0, 0, 1, 8'd7, 8'd8, 8'd9);
        idle_step();
        step(0, 0, 0, 1, 0, 8'd0, 8'd0, 8'd0);
        chk("rst_cmt_pre", 32'({editing, edit_field}), 32'({1'b0, 2'd3}));
        #2 zero_inputs();
        reset = 1'b1;
        #1 chk_reset_outputs("rst_cmt");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            idle_step();
            chk($sformatf("rst_cmt_strb%0d", k), 32'({set_time, set_alarm}), 32'(0));
        end

        // randomized levels against the reference model
        do_reset();
        rm = 0; ri = 0; rd = 0; ro = 0; quiet = 0;
        for (int c = 0; c < 3000; c++) begin
            if (quiet > 0) begin
                quiet--;
                rm = 0; ri = 0; rd = 0; ro = 0;
            end else begin
                if ($urandom_range(0, 99) < 10) rm = ~rm;
                if ($urandom_range(0, 99) < 20) ri = ~ri;
                if ($urandom_range(0, 99) < 15) rd = ~rd;
                if ($urandom_range(0, 99) < 4)  ro = ~ro;
                if ($urandom_range(0, 149) == 0) quiet = 40;
            end
            step(rm, ri, rd, ro, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)),
                 8'($urandom_range(0, 63)), 8'($urandom_range(0, 63)));
            chk("rnd_vals", 32'({set_hour, set_min, set_sec}),
                32'({8'(mv[0]), 8'(mv[1]), 8'(mv[2])}));
            chk("rnd_strb", 32'({set_time, set_alarm}), 32'({e_t, e_a}));
            chk("rnd_stat", 32'({editing, edit_field, blink}),
                32'({(md >= 1 && md <= 3), ((md >= 1 && md <= 3) ? 2'(md - 1) : 2'd3), e_blink}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
